pipeline_hazard_ctrl: RTL and testbench

//  Hazard and run-control unit for the 5-stage RV32 pipeline datapath.
//  - Forwarding: drives ForwardAE/ForwardBE.
//  - Load-use: drives the StallF/StallD/FlushD/FlushE controls.
//  - Debug run-control FSM: halt, drain, single/multi-step, resume of the core.

---
 rtl/pipeline_hazard_ctrl.sv | 161 ++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and debug run-control unit for the 5-stage RV32 pipeline: forwarding, load-use stall,
// halt/drain/step FSM. Optional perf counters enabled by defining HAZ_PERF_CNT_EN.
module pipeline_hazard_ctrl #(
   parameter int unsigned REG_AW  = 5,
   parameter int unsigned STEP_W  = 8,
   parameter int unsigned DRAIN_N = 4
) (
   input  logic              clk,
   input  logic              rst_i,
   input  logic [REG_AW-1:0] rs1_d,
   input  logic [REG_AW-1:0] rs2_d,
   input  logic [REG_AW-1:0] rs1_e,
   input  logic [REG_AW-1:0] rs2_e,
   input  logic [REG_AW-1:0] rd_e,
   input  logic [REG_AW-1:0] rd_m,
   input  logic [REG_AW-1:0] rd_w,
   input  logic              pcsrc_e,
   input  logic              resultsrc_e0,
   input  logic              regwrite_m,
   input  logic              regwrite_w,
   input  logic              halt_req_i,
   input  logic              resume_i,
   input  logic              step_i,
   input  logic [STEP_W-1:0] step_cnt_i,
   output logic              stall_f_o,
   output logic              stall_d_o,
   output logic              flush_d_o,
   output logic              flush_e_o,
   output logic [1:0]        forward_ae_o,
   output logic [1:0]        forward_be_o,
   output logic              halted_o
`ifdef HAZ_PERF_CNT_EN
   ,
   output logic [31:0]       lu_stall_cnt_o,
   output logic [31:0]       flush_cnt_o
`endif
);

   localparam int unsigned DCW = $clog2(DRAIN_N + 1);

   typedef enum logic [1:0] {StRun, StDrain, StHalted, StStep} state_e;

   state_e            r_state;
   logic [DCW-1:0]    r_drain_cnt;
   logic [STEP_W-1:0] r_step_rem;
   logic              w_lw;
   logic [1:0]        w_fwd_a;
   logic [1:0]        w_fwd_b;

   // A taken branch flushes the load's consumer anyway, so it never needs a stall.
   assign w_lw = resultsrc_e0 && (rd_e != '0) && ((rs1_d == rd_e) || (rs2_d == rd_e)) && !pcsrc_e;

   always_comb begin
      w_fwd_a = 2'b00;
      if ((rs1_e != '0) && (rs1_e == rd_m) && regwrite_m)      w_fwd_a = 2'b10;
      else if ((rs1_e != '0) && (rs1_e == rd_w) && regwrite_w) w_fwd_a = 2'b01;
      w_fwd_b = 2'b00;
      if ((rs2_e != '0) && (rs2_e == rd_m) && regwrite_m)      w_fwd_b = 2'b10;
      else if ((rs2_e != '0) && (rs2_e == rd_w) && regwrite_w) w_fwd_b = 2'b01;
   end

   always_comb begin
      stall_f_o    = w_lw;
      stall_d_o    = w_lw;
      flush_d_o    = pcsrc_e;
      flush_e_o    = w_lw | pcsrc_e;
      forward_ae_o = w_fwd_a;
      forward_be_o = w_fwd_b;
      halted_o     = 1'b0;
      unique case (r_state)
         StDrain: begin
            stall_f_o = !pcsrc_e;
            flush_d_o = !w_lw;
         end
         StHalted: begin
            stall_f_o = 1'b1;
            stall_d_o = 1'b0;
            flush_d_o = 1'b1;
            flush_e_o = 1'b0;
            halted_o  = 1'b1;
         end
         default: ;
      endcase
      if (rst_i) begin
         stall_f_o    = 1'b0;
         stall_d_o    = 1'b0;
         flush_d_o    = 1'b1;
         flush_e_o    = 1'b1;
         forward_ae_o = 2'b00;
         forward_be_o = 2'b00;
         halted_o     = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst_i) begin
         r_state     <= StRun;
         r_drain_cnt <= '0;
         r_step_rem  <= '0;
      end else begin
         unique case (r_state)
            StRun: begin
               if (halt_req_i) begin
                  r_state     <= StDrain;
                  r_drain_cnt <= '0;
               end
            end
            StDrain: begin
               // Only non-stalled cycles move instructions towards retirement.
               if (!w_lw) begin
                  r_drain_cnt <= r_drain_cnt + DCW'(1);
                  if (r_drain_cnt == DCW'(DRAIN_N - 1)) r_state <= StHalted;
               end
            end
            StHalted: begin
               if (resume_i) begin
                  r_state <= StRun;
               end else if (step_i) begin
                  r_state    <= StStep;
                  r_step_rem <= (step_cnt_i == '0) ? STEP_W'(1) : step_cnt_i;
               end
            end
            StStep: begin
               if (halt_req_i) begin
                  r_state     <= StDrain;
                  r_drain_cnt <= '0;
                  r_step_rem  <= '0;
               end else if (!w_lw) begin
                  r_step_rem <= r_step_rem - STEP_W'(1);
                  if (r_step_rem == STEP_W'(1)) begin
                     r_state     <= StDrain;
                     r_drain_cnt <= '0;
                  end
               end
            end
            default: r_state <= StRun;
         endcase
      end
   end

`ifdef HAZ_PERF_CNT_EN
   logic [31:0] r_lu_cnt;
   logic [31:0] r_fl_cnt;

   always_ff @(posedge clk) begin
      if (rst_i) begin
         r_lu_cnt <= '0;
         r_fl_cnt <= '0;
      end else begin
         if (w_lw && (r_lu_cnt != 32'hFFFF_FFFF))    r_lu_cnt <= r_lu_cnt + 32'd1;
         if (pcsrc_e && (r_fl_cnt != 32'hFFFF_FFFF)) r_fl_cnt <= r_fl_cnt + 32'd1;
      end
   end

   assign lu_stall_cnt_o = r_lu_cnt;
   assign flush_cnt_o    = r_fl_cnt;
`else
   // No performance counters in this build.
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomised scoreboard bench for pipeline_hazard_ctrl; the reference model tracks run-control
// as "cycles left to drain / fetch slots left to step" counts rather than FSM states.
module tb_pipeline_hazard_ctrl;

   localparam int DRAIN_N = 4;

   logic       clk = 1'b0;
   logic       rst_i;
   logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
   logic       pcsrc_e, resultsrc_e0, regwrite_m, regwrite_w;
   logic       halt_req_i, resume_i, step_i;
   logic [7:0] step_cnt_i;
   logic       stall_f_o, stall_d_o, flush_d_o, flush_e_o, halted_o;
   logic [1:0] forward_ae_o, forward_be_o;
   logic [31:0] lu_cnt_w, fl_cnt_w;

   always #5 clk = ~clk;

   pipeline_hazard_ctrl dut (
      .clk          (clk),
      .rst_i        (rst_i),
      .rs1_d        (rs1_d),
      .rs2_d        (rs2_d),
      .rs1_e        (rs1_e),
      .rs2_e        (rs2_e),
      .rd_e         (rd_e),
      .rd_m         (rd_m),
      .rd_w         (rd_w),
      .pcsrc_e      (pcsrc_e),
      .resultsrc_e0 (resultsrc_e0),
      .regwrite_m   (regwrite_m),
      .regwrite_w   (regwrite_w),
      .halt_req_i   (halt_req_i),
      .resume_i     (resume_i),
      .step_i       (step_i),
      .step_cnt_i   (step_cnt_i),
      .stall_f_o    (stall_f_o),
      .stall_d_o    (stall_d_o),
      .flush_d_o    (flush_d_o),
      .flush_e_o    (flush_e_o),
      .forward_ae_o (forward_ae_o),
      .forward_be_o (forward_be_o),
      .halted_o     (halted_o)
`ifdef HAZ_PERF_CNT_EN
      ,
      .lu_stall_cnt_o (lu_cnt_w),
      .flush_cnt_o    (fl_cnt_w)
`endif
   );

`ifndef HAZ_PERF_CNT_EN
   assign lu_cnt_w = 32'd0;
   assign fl_cnt_w = 32'd0;
`endif

   // Output vector: {stall_f, stall_d, flush_d, flush_e, fwd_a, fwd_b, halted, lu_cnt, fl_cnt}
   typedef logic [72:0] vec_t;
   vec_t sb[$];
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;

   // Reference model state
   bit      m_halted = 0;
   int      m_drain_left = 0;
   int      m_steps = 0;
   longint  m_lu = 0;
   longint  m_fl = 0;

   function automatic logic [1:0] fwd(input logic [4:0] rs);
      if (rs != 0 && rs == rd_m && regwrite_m) return 2'b10;
      if (rs != 0 && rs == rd_w && regwrite_w) return 2'b01;
      return 2'b00;
   endfunction

   function automatic bit lw_now();
      return resultsrc_e0 && rd_e != 0 && (rs1_d == rd_e || rs2_d == rd_e) && !pcsrc_e;
   endfunction

   function automatic vec_t expected();
      bit sf, sd, fd, fe, h;
      bit lw;
      logic [1:0] fa, fb;
      lw = lw_now();
      fa = fwd(rs1_e);
      fb = fwd(rs2_e);
      h  = 0;
      if (rst_i) begin
         sf = 0; sd = 0; fd = 1; fe = 1; fa = 2'b00; fb = 2'b00;
      end else if (m_halted) begin
         sf = 1; sd = 0; fd = 1; fe = 0; h = 1;
      end else if (m_drain_left > 0) begin
         sf = !pcsrc_e; sd = lw; fd = !lw; fe = lw | pcsrc_e;
      end else begin
         sf = lw; sd = lw; fd = pcsrc_e; fe = lw | pcsrc_e;
      end
`ifdef HAZ_PERF_CNT_EN
      return {sf, sd, fd, fe, fa, fb, h, m_lu[31:0], m_fl[31:0]};
`else
      return {sf, sd, fd, fe, fa, fb, h, 64'd0};
`endif
   endfunction

   task automatic model_edge();
      bit lw;
      lw = lw_now();
      if (rst_i) begin
         m_halted = 0; m_drain_left = 0; m_steps = 0; m_lu = 0; m_fl = 0;
         return;
      end
      if (lw && m_lu < 64'hFFFF_FFFF) m_lu++;
      if (pcsrc_e && m_fl < 64'hFFFF_FFFF) m_fl++;
      if (m_halted) begin
         if (resume_i) m_halted = 0;
         else if (step_i) begin
            m_halted = 0;
            m_steps  = (step_cnt_i == 0) ? 1 : int'(step_cnt_i);
         end
      end else if (m_drain_left > 0) begin
         if (!lw) begin
            m_drain_left--;
            if (m_drain_left == 0) m_halted = 1;
         end
      end else if (m_steps > 0) begin
         if (halt_req_i) begin
            m_steps = 0;
            m_drain_left = DRAIN_N;
         end else if (!lw) begin
            m_steps--;
            if (m_steps == 0) m_drain_left = DRAIN_N;
         end
      end else if (halt_req_i) begin
         m_drain_left = DRAIN_N;
      end
   endtask

   // Inputs are already applied; queue the expectation, then advance across one edge.
   task automatic issue();
      sb.push_back(expected());
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic set_idle();
      rst_i = 0; rs1_d = 0; rs2_d = 0; rs1_e = 0; rs2_e = 0; rd_e = 0; rd_m = 0; rd_w = 0;
      pcsrc_e = 0; resultsrc_e0 = 0; regwrite_m = 0; regwrite_w = 0;
      halt_req_i = 0; resume_i = 0; step_i = 0; step_cnt_i = 0;
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         set_idle();
         issue();
      end
   endtask

   always @(negedge clk) begin
      vec_t got, exp_v;
      cyc++;
      if (sb.size() > 0) begin
         exp_v = sb.pop_front();
         got = {stall_f_o, stall_d_o, flush_d_o, flush_e_o, forward_ae_o, forward_be_o,
                halted_o, lu_cnt_w, fl_cnt_w};
         checks++;
         if (got !== exp_v) begin
            failures++;
            $display("FAIL outputs cycle=%0d got=%h expected=%h", cyc, got, exp_v);
         end
      end
   end

   initial begin
      set_idle();
      rst_i = 1;
      @(posedge clk);
      #1;
      issue();

      // Forwarding priority: M beats W, x0 never forwards
      set_idle(); rs1_e = 5; rd_m = 5; regwrite_m = 1; rd_w = 5; regwrite_w = 1; issue();
      regwrite_m = 0; issue();
      rs1_e = 0; issue();
      // Load-use stall, then suppressed by a taken branch
      set_idle(); resultsrc_e0 = 1; rd_e = 7; rs2_d = 7; issue();
      pcsrc_e = 1; issue();
      // Halt and drain with no hazards
      set_idle(); halt_req_i = 1; issue();
      idle_cycles(6);
      // Step three slots, then zero-count step
      set_idle(); step_i = 1; step_cnt_i = 3; issue();
      idle_cycles(9);
      set_idle(); step_i = 1; step_cnt_i = 0; issue();
      idle_cycles(7);
      // Resume, halt, branch and load-use inside drain
      set_idle(); resume_i = 1; issue();
      set_idle(); halt_req_i = 1; issue();
      set_idle(); pcsrc_e = 1; issue();
      set_idle(); resultsrc_e0 = 1; rd_e = 3; rs1_d = 3; issue();
      idle_cycles(5);
      // Reset in the middle of a drain
      set_idle(); resume_i = 1; issue();
      set_idle(); halt_req_i = 1; issue();
      idle_cycles(2);
      set_idle(); rst_i = 1; issue();
      idle_cycles(2);
      // Ten load-use cycles then reset
      for (int i = 0; i < 10; i++) begin
         set_idle(); resultsrc_e0 = 1; rd_e = 9; rs1_d = 9; issue();
      end
      set_idle(); rst_i = 1; issue();
      idle_cycles(1);

      for (int i = 0; i < 4000; i++) begin
         rst_i        = ($urandom_range(0, 299) == 0);
         rs1_d        = 5'($urandom_range(0, 3));
         rs2_d        = 5'($urandom_range(0, 3));
         rs1_e        = 5'($urandom_range(0, 3));
         rs2_e        = 5'($urandom_range(0, 3));
         rd_e         = 5'($urandom_range(0, 3));
         rd_m         = 5'($urandom_range(0, 3));
         rd_w         = 5'($urandom_range(0, 3));
         pcsrc_e      = ($urandom_range(0, 5) == 0);
         resultsrc_e0 = ($urandom_range(0, 2) == 0);
         regwrite_m   = 1'($urandom_range(0, 1));
         regwrite_w   = 1'($urandom_range(0, 1));
         halt_req_i   = ($urandom_range(0, 15) == 0);
         resume_i     = ($urandom_range(0, 11) == 0);
         step_i       = ($urandom_range(0, 5) == 0);
         step_cnt_i   = 8'($urandom_range(0, 6));
         issue();
      end

      set_idle();
      @(negedge clk);
      #1;
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain left=%0d expected=0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
